xbee_cmd_rx: RTL and testbench
==============================

Name: xbee_cmd_rx

Overview:
Upstream receive stage for the motor/servo command path. Deserialises the XBee UART line (8N1) and assembles two-byte command packets (header, value). Emits one 9-bit command word per packet, data[8] = 0 for motor and 1 for servo, data[7:0] = duty value, with a single-cycle data_ready strobe. The downstream command controller latches the word on that strobe.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 9600, serial bit rate
CLKS_PER_BIT, CLK_FREQ/BAUD, clocks per bit; must be >= 8
TIMEOUT_CLKS, 20*CLKS_PER_BIT, maximum idle gap allowed between the header byte and the value byte
HDR_MOTOR, 8'h4D, header byte ('M') selecting motor
HDR_SERVO, 8'h53, header byte ('S') selecting servo

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  synchronous, active-low reset
rx  in  1  asynchronous serial input from the XBee; idle high
data  out  9  {kind, value}; holds its last value between packets
data_ready  out  1  one-cycle pulse; data is valid in that same cycle
frame_err  out  1  one-cycle pulse; stop bit sampled low
sync_err  out  1  one-cycle pulse; bad header or value-byte timeout

Behaviour:
- Reset (rst_n = 0 at posedge):
  - data = 0; data_ready, frame_err, sync_err = 0.
  - Synchroniser flops = 1.
  - UART FSM = IDLE, parser = P_HDR, all counters = 0.
  - Reset mid-byte or mid-packet discards all partial state, with no pulses.
- Input: 2-flop synchroniser on rx. All logic below uses the synchronised signal rx_s, which is 2 cycles late.
- UART FSM (IDLE, START, DATA, STOP, BREAK):
  - IDLE: rx_s = 0 -> START, bit counter cleared.
  - START: at count CLKS_PER_BIT/2 - 1, re-sample rx_s. 1 -> IDLE (glitch, no error). 0 -> DATA.
  - DATA: sample rx_s every CLKS_PER_BIT clocks, 8 bits, LSB first, into a shift register. After bit 7 -> STOP.
  - STOP: sample after CLKS_PER_BIT clocks.
    - 1: byte_valid internal pulse for one cycle -> IDLE.
    - 0: frame_err pulse, byte discarded -> BREAK.
  - BREAK: wait for rx_s = 1 -> IDLE. No new start bit is detected during BREAK.
- Parser FSM (P_HDR, P_VAL), advanced only on byte_valid or frame_err:
  - P_HDR, byte_valid:
    - byte == HDR_MOTOR -> kind = 0, go to P_VAL.
    - byte == HDR_SERVO -> kind = 1, go to P_VAL.
    - Any other byte -> sync_err pulse, stay in P_HDR.
  - P_VAL, byte_valid: register data <= {kind, byte} and pulse data_ready in the next cycle -> P_HDR.
  - P_VAL, frame_err -> P_HDR (packet aborted). frame_err is the only pulse; no sync_err.
  - P_VAL timeout:
    - Counter clears on entry to P_VAL and counts while no byte is completing.
    - On reaching TIMEOUT_CLKS: sync_err pulse -> P_HDR.
    - If byte_valid and the timeout occur in the same cycle, byte_valid wins (packet accepted, no sync_err).
- Latency: data_ready is asserted exactly 1 cycle after the value byte's stop-bit sample cycle.
- At most one of data_ready, frame_err, sync_err is high in any cycle.
- Back-to-back packets with zero idle gap are supported; a start bit immediately following a stop bit is detected.
- There is no flow control. The consumer must accept data_ready every cycle it is asserted.

Test Plan:
All scenarios use CLK_FREQ = 1_000_000, BAUD = 100_000 (CLKS_PER_BIT = 10), TIMEOUT_CLKS = 200.
- Send 0x4D then 0x80 -> one data_ready pulse with data = 9'h080, 1 cycle after the second stop-bit sample; no error pulses.
- Send 0x53 then 0x3C, then immediately 0x4D, 0xFF with no gap -> data = 9'h13C, then data = 9'h0FF; exactly two data_ready pulses.
- Drive rx low for 3 cycles on an idle line, then send 0x4D, 0x01 -> no byte and no error from the glitch; data = 9'h001.
- Send 0x53 with stop bit 0, hold rx low 50 cycles, release, then send 0x53, 0x10 -> one frame_err; no data_ready until data = 9'h110.
- Send 0x41 -> sync_err. Then send 0x4D, idle 250 cycles -> sync_err. Then send 0x53, 0x22 -> data = 9'h122; exactly two sync_err pulses in total.
- Assert rst_n = 0 during DATA bit 4 of a value byte, release, then send 0x4D, 0x07 -> no pulses from the partial byte; data = 9'h007 and reads 0 while in reset.

Source files
------------

// File: rtl/xbee_cmd_rx.sv
// xbee_cmd_rx: XBee UART (8N1) receiver plus two-byte command packet parser.
// A packet is a header byte ('M' motor / 'S' servo) followed by a duty value.
// Each completed packet produces a 9-bit {kind, value} word with a one-cycle
// data_ready strobe. Framing problems and packet sync problems are reported
// as one-cycle pulses aligned with where data_ready would have appeared.
module xbee_cmd_rx #(
    parameter int          CLK_FREQ     = 50_000_000,
    parameter int          BAUD         = 9600,
    parameter int          CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int          TIMEOUT_CLKS = 20 * CLKS_PER_BIT,
    parameter logic [7:0]  HDR_MOTOR    = 8'h4D,
    parameter logic [7:0]  HDR_SERVO    = 8'h53
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [8:0] data,
    output logic       data_ready,
    output logic       frame_err,
    output logic       sync_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

    typedef enum logic {
        P_HDR = 1'b0,
        P_VAL = 1'b1
    } parse_state_t;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic rx_m;
    logic rx_s;

    // Two-flop synchroniser; resets to the idle (high) line level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // ------------------------------------------------------------------
    // UART receive FSM
    // ------------------------------------------------------------------
    uart_state_t     u_state;
    uart_state_t     u_state_nx;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;

    logic half_tick;
    logic bit_tick;
    logic sample_bit;
    logic byte_valid;
    logic stop_low;
    logic cnt_run;

    assign half_tick = (cnt == HALF_LAST);
    assign bit_tick  = (cnt == BIT_LAST);

    // UART state register
    always_ff @(posedge clk) begin
        if (!rst_n) u_state <= IDLE;
        else        u_state <= u_state_nx;
    end

    // UART next-state: start detect, mid-start recheck, 8 data bits, stop check
    always_comb begin
        u_state_nx = u_state;
        case (u_state)
            IDLE:  if (!rx_s)                     u_state_nx = START;
            START: if (half_tick)                 u_state_nx = rx_s ? IDLE : DATA;
            DATA:  if (bit_tick && bit_idx == 3'd7) u_state_nx = STOP;
            STOP:  if (bit_tick)                  u_state_nx = rx_s ? IDLE : BREAK;
            BREAK: if (rx_s)                      u_state_nx = IDLE;
            default:                              u_state_nx = IDLE;
        endcase
    end

    // UART outputs: sample strobes, byte completion and framing error
    always_comb begin
        sample_bit = 1'b0;
        byte_valid = 1'b0;
        stop_low   = 1'b0;
        cnt_run    = 1'b0;
        case (u_state)
            START: cnt_run = (u_state_nx == START);
            DATA: begin
                sample_bit = bit_tick;
                cnt_run    = !bit_tick;
            end
            STOP: begin
                byte_valid = bit_tick && rx_s;
                stop_low   = bit_tick && !rx_s;
                cnt_run    = !bit_tick;
            end
            default: ;
        endcase
    end

    // Bit timing counter, bit index and LSB-first shift register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            cnt <= cnt_run ? cnt + 1'b1 : '0;
            if (u_state == START)
                bit_idx <= '0;
            else if (sample_bit)
                bit_idx <= bit_idx + 1'b1;
            if (sample_bit)
                shreg <= {rx_s, shreg[7:1]};
        end
    end

    // ------------------------------------------------------------------
    // Packet parser FSM
    // ------------------------------------------------------------------
    parse_state_t    p_state;
    parse_state_t    p_state_nx;
    logic [TW-1:0]   tcnt;
    logic            kind;

    logic hdr_motor;
    logic hdr_servo;
    logic hdr_hit;
    logic hdr_bad;
    logic val_take;
    logic tmo_hit;

    // Parser state register
    always_ff @(posedge clk) begin
        if (!rst_n) p_state <= P_HDR;
        else        p_state <= p_state_nx;
    end

    // Parser next-state: header opens a packet; value, framing error or timeout closes it
    always_comb begin
        p_state_nx = p_state;
        case (p_state)
            P_HDR:   if (hdr_hit)                          p_state_nx = P_VAL;
            P_VAL:   if (byte_valid || stop_low || tmo_hit) p_state_nx = P_HDR;
            default:                                       p_state_nx = P_HDR;
        endcase
    end

    // Parser decode; a completing byte always beats the timeout in the same cycle
    always_comb begin
        hdr_motor = byte_valid && (shreg == HDR_MOTOR);
        hdr_servo = byte_valid && (shreg == HDR_SERVO);
        hdr_hit   = (p_state == P_HDR) && (hdr_motor || hdr_servo);
        hdr_bad   = (p_state == P_HDR) && byte_valid && !(hdr_motor || hdr_servo);
        val_take  = (p_state == P_VAL) && byte_valid;
        tmo_hit   = (p_state == P_VAL) && !byte_valid && !stop_low && (tcnt == TMO_LAST);
    end

    // Registered strobes, held command word, packet kind and value-gap timer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data       <= '0;
            data_ready <= 1'b0;
            frame_err  <= 1'b0;
            sync_err   <= 1'b0;
            kind       <= 1'b0;
            tcnt       <= '0;
        end else begin
            data_ready <= val_take;
            frame_err  <= stop_low;
            sync_err   <= hdr_bad || tmo_hit;
            if (val_take)
                data <= {kind, shreg};
            if (hdr_hit)
                kind <= hdr_servo;
            // Timer is zero in P_HDR, so it starts from zero on every packet
            if (p_state == P_VAL && p_state_nx == P_VAL)
                tcnt <= tcnt + 1'b1;
            else
                tcnt <= '0;
        end
    end

endmodule

// File: tb/tb_xbee_cmd_rx.sv
// Bench for xbee_cmd_rx: table-driven packets, hand-written corner cases
// (glitch, framing error, bad header, timeout, mid-byte reset) and a random
// phase checked against a byte-level packet model.
`timescale 1ns/1ps
module tb_xbee_cmd_rx;

    localparam int CPB = 10;
    localparam int TMO = 200;
    localparam int P   = 10;
    localparam logic [7:0] HM = 8'h4D;
    localparam logic [7:0] HS = 8'h53;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [8:0] data;
    logic       data_ready;
    logic       frame_err;
    logic       sync_err;

    always #(P/2) clk = ~clk;

    xbee_cmd_rx #(
        .CLK_FREQ    (1_000_000),
        .BAUD        (100_000),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .data_ready(data_ready),
        .frame_err (frame_err),
        .sync_err  (sync_err)
    );

    int tests = 0;
    int fails = 0;

    // observed pulse totals
    int      n_ready = 0;
    int      n_ferr  = 0;
    int      n_serr  = 0;
    longint  t_ready = 0;
    longint  t_start = 0;

    // model: expected totals and packet state
    int         e_ready = 0;
    int         e_ferr  = 0;
    int         e_serr  = 0;
    logic [8:0] e_data  = '0;
    bit         m_pend  = 0;
    bit         m_kind  = 0;
    int         m_gap   = 0;

    typedef struct {
        logic [7:0] hdr;
        logic [7:0] val;
        logic [8:0] exp;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse monitor; also checks that strobes never overlap
    always @(negedge clk) begin
        if (data_ready) begin
            n_ready++;
            t_ready = $time;
        end
        if (frame_err) n_ferr++;
        if (sync_err)  n_serr++;
        if (data_ready || frame_err || sync_err)
            chk("one_hot", int'(data_ready) + int'(frame_err) + int'(sync_err), 1);
    end

    // Byte-level packet model
    task automatic model_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            e_ferr++;
            m_pend = 0;
        end else if (!m_pend) begin
            if (b == HM)      begin m_pend = 1; m_kind = 0; end
            else if (b == HS) begin m_pend = 1; m_kind = 1; end
            else              e_serr++;
        end else begin
            e_ready++;
            e_data = {m_kind, b};
            m_pend = 0;
        end
        m_gap = 0;
    endtask

    task automatic model_reset();
        m_pend = 0;
        m_gap  = 0;
        e_data = '0;
    endtask

    // Called just after a negedge; returns just after a negedge
    task automatic send_byte(input logic [7:0] b, input bit ok);
        logic [9:0] bits;
        bits = {ok, b, 1'b0};
        t_start = $time;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (CPB) @(negedge clk);
        end
        model_byte(b, ok);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
        m_gap += n;
        // gaps used here are either well short of or well past the timeout
        if (m_pend && m_gap > TMO + 10) begin
            e_serr++;
            m_pend = 0;
        end
    endtask

    task automatic check_totals(input string tag);
        chk({tag, "_ready"}, n_ready, e_ready);
        chk({tag, "_ferr"},  n_ferr,  e_ferr);
        chk({tag, "_serr"},  n_serr,  e_serr);
        chk({tag, "_data"},  int'(data), int'(e_data));
    endtask

    int         r0, f0, s0;
    logic [7:0] h, v;
    bit         ok_h, ok_v, prev_bad;
    int         g;

    initial begin
        tbl[0] = '{8'h4D, 8'h80, 9'h080};
        tbl[1] = '{8'h53, 8'h3C, 9'h13C};
        tbl[2] = '{8'h4D, 8'hFF, 9'h0FF};
        tbl[3] = '{8'h53, 8'h00, 9'h100};
        tbl[4] = '{8'h53, 8'h53, 9'h153};
        tbl[5] = '{8'h4D, 8'h4D, 9'h04D};

        // reset state
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data",  int'(data), 0);
        chk("rst_ready", int'(data_ready), 0);
        chk("rst_ferr",  int'(frame_err), 0);
        chk("rst_serr",  int'(sync_err), 0);
        rst_n = 1'b1;
        idle(10);

        // back-to-back packets from the table, no idle between bytes
        for (int i = 0; i < 6; i++) begin
            r0 = n_ready;
            send_byte(tbl[i].hdr, 1'b1);
            send_byte(tbl[i].val, 1'b1);
            chk("tbl_data", int'(data), int'(tbl[i].exp));
            chk("tbl_ready_cnt", n_ready - r0, 1);
            if (i == 0)
                chk("latency", int'((t_ready - t_start) / P), 98);
            check_totals("tbl");
        end
        idle(10);

        // short low glitch on an idle line is ignored
        f0 = n_ferr; s0 = n_serr; r0 = n_ready;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(20);
        chk("glitch_pulses", (n_ready - r0) + (n_ferr - f0) + (n_serr - s0), 0);
        send_byte(8'h4D, 1'b1);
        send_byte(8'h01, 1'b1);
        chk("glitch_data", int'(data), 9'h001);
        check_totals("glitch");

        // bad stop bit, line held low, then a clean packet
        f0 = n_ferr; r0 = n_ready;
        send_byte(8'h53, 1'b0);
        repeat (50) @(negedge clk);
        chk("ferr_cnt", n_ferr - f0, 1);
        chk("ferr_no_ready", n_ready - r0, 0);
        idle(10);
        send_byte(8'h53, 1'b1);
        send_byte(8'h10, 1'b1);
        chk("ferr_data", int'(data), 9'h110);
        chk("ferr_ready", n_ready - r0, 1);
        check_totals("ferr");

        // bad header, then value-byte timeout, then a good packet
        s0 = n_serr;
        send_byte(8'h41, 1'b1);
        chk("badhdr_serr", n_serr - s0, 1);
        send_byte(8'h4D, 1'b1);
        idle(250);
        chk("tmo_serr", n_serr - s0, 2);
        send_byte(8'h53, 1'b1);
        send_byte(8'h22, 1'b1);
        chk("tmo_data", int'(data), 9'h122);
        chk("tmo_serr_total", n_serr - s0, 2);
        check_totals("tmo");

        // reset during data bit 4 of a value byte
        r0 = n_ready; f0 = n_ferr; s0 = n_serr;
        send_byte(8'h4D, 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0 || i == 1 || i == 2);
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_data", int'(data), 0);
        model_reset();
        rst_n = 1'b1;
        idle(20);
        chk("midrst_pulses", (n_ready - r0) + (n_ferr - f0) + (n_serr - s0), 0);
        send_byte(8'h4D, 1'b1);
        send_byte(8'h07, 1'b1);
        chk("midrst_data2", int'(data), 9'h007);
        check_totals("midrst");
        idle(10);

        // random packets against the model
        prev_bad = 0;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 2))
                0:       h = HM;
                1:       h = HS;
                default: h = 8'($urandom);
            endcase
            v    = 8'($urandom);
            ok_h = ($urandom_range(0, 9) != 0);
            ok_v = ($urandom_range(0, 9) != 0);

            g = prev_bad ? int'($urandom_range(3, 10)) : int'($urandom_range(0, 12));
            if (g > 0) idle(g);
            send_byte(h, ok_h);
            check_totals("rnd_h");
            prev_bad = !ok_h;

            if (prev_bad)                       g = int'($urandom_range(3, 10));
            else if ($urandom_range(0, 5) == 0) g = int'($urandom_range(TMO + 15, TMO + 40));
            else                                g = int'($urandom_range(0, 12));
            if (g > 0) idle(g);
            send_byte(v, ok_v);
            check_totals("rnd_v");
            prev_bad = !ok_v;
        end
        idle(20);
        check_totals("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
